parallel_to_serial: RTL and testbench

Transmit-side serializer that accepts DATA_WIDTH-bit words over a valid/ready handshake and shifts them out one bit at a time on a single serial line. It is the counterpart of the team's serial-to-parallel receiver and sits between the word-level datapath and the serial link. A one-entry holding register decouples the handshake from the shifter, so back-to-back words stream without idle bits. Bit rate is set by an external bit-enable strobe.

---
 rtl/p2s_pkg.sv | 17 +
 rtl/p2s_hold_buffer.sv | 33 +++
 rtl/parallel_to_serial.sv | 100 ++++++++++
 tb/tb_parallel_to_serial.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared types, defaults and width helper for the parallel-to-serial link
package p2s_pkg;

  localparam int P2S_DATA_WIDTH = 32;
  localparam bit P2S_MSB_FIRST  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/p2s_hold_buffer.sv
// rtl/p2s_hold_buffer.sv - single-entry valid/ready holding register in front of the shifter
module p2s_hold_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             valid,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic push;

  assign ready = !full && !reset;
  assign push  = valid && ready;

  // A push wins over a simultaneous pop: the popped word was already read from data.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= in;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - word-to-bit serializer with gapless reload, paced by bit_en
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int DATA_WIDTH = P2S_DATA_WIDTH,
  parameter bit MSB_FIRST  = P2S_MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  bit_en,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_start,
  output logic                  frame_last
);

  localparam int              CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  p2s_state_t            state, state_next;
  logic [DATA_WIDTH-1:0] shifter, shifter_next, shifted;
  logic [CNT_W-1:0]      bit_cnt, cnt_next;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  pop;

  p2s_hold_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk  (clk),
    .reset(reset),
    .in   (data_in),
    .valid(data_valid),
    .ready(data_ready),
    .pop  (pop),
    .data (hold_data),
    .full (hold_full)
  );

  assign shifted = MSB_FIRST ? {shifter[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, shifter[DATA_WIDTH-1:1]};

  always_comb begin
    state_next   = state;
    shifter_next = shifter;
    cnt_next     = bit_cnt;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          pop          = 1'b1;
          shifter_next = hold_data;
          cnt_next     = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (bit_cnt == LAST_CNT) begin
            // Last bit leaving: chain straight into the held word if there is one.
            if (hold_full) begin
              pop          = 1'b1;
              shifter_next = hold_data;
              cnt_next     = '0;
            end else begin
              shifter_next = '0;
              cnt_next     = '0;
              state_next   = IDLE;
            end
          end else begin
            shifter_next = shifted;
            cnt_next     = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shifter <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      shifter <= shifter_next;
      bit_cnt <= cnt_next;
    end
  end

  assign serial_valid = (state == SHIFT);
  assign serial_out   = serial_valid && (MSB_FIRST ? shifter[DATA_WIDTH-1] : shifter[0]);
  assign frame_start  = serial_valid && (bit_cnt == '0);
  assign frame_last   = serial_valid && (bit_cnt == LAST_CNT);

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed self-checking bench for parallel_to_serial
module tb_parallel_to_serial;
  import p2s_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] word;
    int           period;
    logic [3:0]   m_first4;
    logic [3:0]   m_last4;
    logic [3:0]   l_first4;
    logic [3:0]   l_last4;
    int           valid_cycles;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         bit_en;
  logic         data_ready, serial_out, serial_valid, frame_start, frame_last;
  logic         l_ready, l_out, l_valid, l_start, l_last;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  parallel_to_serial #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .bit_en(bit_en), .serial_out(serial_out),
    .serial_valid(serial_valid), .frame_start(frame_start), .frame_last(frame_last)
  );

  parallel_to_serial #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_ready), .bit_en(bit_en), .serial_out(l_out),
    .serial_valid(l_valid), .frame_start(l_start), .frame_last(l_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_bits(input logic [W-1:0] w, input int idx, input bit msb);
    int b;
    b = msb ? (W - 1 - idx) : idx;
    return {1'b1, w[b], idx == 0, idx == W - 1};
  endfunction

  task automatic run_vector(input vec_t v);
    logic [W-1:0] seq_m, seq_l;
    int idx, vcnt;
    seq_m = '0; seq_l = '0; vcnt = 0;
    @(negedge clk);
    check("ready_before_accept", {data_ready, l_ready}, 2'b11);
    data_in = v.word; data_valid = 1'b1; bit_en = 1'b0;
    @(negedge clk);
    data_valid = 1'b0;
    check("ready_while_held", {data_ready, l_ready}, 2'b00);
    check("idle_before_load", {serial_valid, l_valid}, 2'b00);
    for (int k = 0; k <= W * v.period; k++) begin
      @(negedge clk);
      idx = k / v.period;
      if (k == 0) check("ready_after_load", data_ready, 1'b1);
      if (k < W * v.period) begin
        check("msb_cycle", {serial_valid, serial_out, frame_start, frame_last}, exp_bits(v.word, idx, 1'b1));
        check("lsb_cycle", {l_valid, l_out, l_start, l_last}, exp_bits(v.word, idx, 1'b0));
        if (k % v.period == 0) begin
          seq_m[W-1-idx] = serial_out;
          seq_l[W-1-idx] = l_out;
        end
      end else begin
        check("msb_idle_after", {serial_valid, serial_out, frame_start, frame_last}, 4'b0000);
        check("lsb_idle_after", {l_valid, l_out, l_start, l_last}, 4'b0000);
      end
      if (serial_valid) vcnt++;
      bit_en = (k % v.period == v.period - 1);
    end
    bit_en = 1'b0;
    check("msb_first4", seq_m[W-1:W-4], v.m_first4);
    check("msb_last4", seq_m[3:0], v.m_last4);
    check("lsb_first4", seq_l[W-1:W-4], v.l_first4);
    check("lsb_last4", seq_l[3:0], v.l_last4);
    check("valid_cycles", vcnt, v.valid_cycles);
  endtask

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, 1, 4'b1010, 4'b1111, 4'b1111, 4'b0101, 32};
    vecs[1] = '{32'h0000_0003, 1, 4'b0000, 4'b0011, 4'b1100, 4'b0000, 32};
    vecs[2] = '{32'h8000_0001, 4, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 128};
    vecs[3] = '{32'h1234_5678, 2, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 64};

    // Reset held with a word offered: nothing accepted, everything quiet.
    reset = 1'b1; data_valid = 1'b1; data_in = 32'hFFFF_FFFF; bit_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ready", {data_ready, l_ready}, 2'b00);
      check("reset_outputs", {serial_valid, serial_out, frame_start, frame_last, l_valid, l_out}, 6'b0);
    end
    reset = 1'b0; data_valid = 1'b0; bit_en = 1'b0;
    @(negedge clk);
    check("ready_after_release", {data_ready, l_ready}, 2'b11);
    @(negedge clk);
    check("no_accept_in_reset", {serial_valid, l_valid}, 2'b00);

    for (int i = 0; i < 3; i++) run_vector(vecs[i]);

    // Back-to-back words must stream with no idle bit between them.
    @(negedge clk);
    data_in = 32'hFFFF_0000; data_valid = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int k = 0; k <= 2 * W; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("b2b_ready_k0", data_ready, 1'b1);
        data_in = 32'h0000_FFFF; data_valid = 1'b1;
      end
      if (k == 1) data_valid = 1'b0;
      if (k >= 1 && k < W) check("b2b_ready_low", data_ready, 1'b0);
      if (k == W) check("b2b_ready_reload", data_ready, 1'b1);
      if (k < W)
        check("b2b_word0", {serial_valid, serial_out, frame_start, frame_last}, exp_bits(32'hFFFF_0000, k, 1'b1));
      else if (k < 2 * W)
        check("b2b_word1", {serial_valid, serial_out, frame_start, frame_last}, exp_bits(32'h0000_FFFF, k - W, 1'b1));
      else
        check("b2b_idle", {serial_valid, frame_start, frame_last}, 3'b000);
    end
    bit_en = 1'b0;

    // Reset mid-frame at bit 10 with a second word pending in hold.
    @(negedge clk);
    data_in = 32'hDEAD_BEEF; data_valid = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    data_in = 32'hCAFE_F00D; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("pending_ready_low", data_ready, 1'b0);
    repeat (9) @(negedge clk);
    check("bit10_before_reset", {serial_valid, serial_out, frame_start, frame_last}, 4'b1100);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {serial_valid, serial_out, frame_start, frame_last}, 4'b0000);
    check("midreset_ready", data_ready, 1'b0);
    reset = 1'b0; bit_en = 1'b0;
    @(negedge clk);
    check("midreset_hold_empty", data_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_stays_idle", {serial_valid, l_valid}, 2'b00);
    end

    run_vector(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
